// File: rtl/down_counter_dec.sv
// Registered down-counting decrementor with borrow/underflow reporting.
// Optional DEC_SATURATE_EN: a decrement at zero holds at zero instead of wrapping to MAXV.
module down_counter_dec #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_en,
    input  logic             clr_uf,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             underflow,
    output logic             sticky_uf
);

    localparam int unsigned MAXV = (1 << WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             underflow_q, underflow_d;
    logic             sticky_uf_q, sticky_uf_d;

    logic             borrow;
    logic [WIDTH-1:0] dec_val;

    // Next-state and next-output logic; load beats dec_en, reset is applied in the register.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        sticky_uf_d = sticky_uf_q & ~clr_uf;

        {borrow, dec_val} = {1'b0, count_q} - (WIDTH + 1)'(1);

        if (load) begin
            count_d = load_val;
            state_d = (load_val == '0) ? EXPIRED : RUN;
        end else if (dec_en) begin
            case (state_q)
                RUN: begin
                    count_d = dec_val;
                    if (count_q == WIDTH'(1)) begin
                        state_d = EXPIRED;
                    end
                end
                EXPIRED: begin
                    // count is 0 here, so the subtraction always borrows
                    underflow_d = borrow;
                    sticky_uf_d = 1'b1;
`ifdef DEC_SATURATE_EN
                    count_d     = '0;
                    state_d     = EXPIRED;
`else
                    count_d     = WIDTH'(MAXV);
                    state_d     = RUN;
`endif
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end

        zero_d = (count_d == '0);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
            sticky_uf_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
            sticky_uf_q <= sticky_uf_d;
        end
    end

    assign count     = count_q;
    assign zero      = zero_q;
    assign busy      = busy_q;
    assign underflow = underflow_q;
    assign sticky_uf = sticky_uf_q;

endmodule

// File: tb/tb_down_counter_dec.sv
// Self-checking bench for down_counter_dec: directed vector table, hand sequences and random stimulus vs a reference model.
module tb_down_counter_dec;

`ifdef DEC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, load, dec_en, clr_uf;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       zero, busy, underflow, sticky_uf;

    int errors = 0;
    int checks = 0;

    // reference model: "loaded" means a load happened since reset; counting iff loaded and nonzero
    int m_count  = 0;
    bit m_loaded = 1'b0;
    bit m_uf     = 1'b0;
    bit m_sticky = 1'b0;

    always #5 clk = ~clk;

    down_counter_dec dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec_en   (dec_en),
        .clr_uf   (clr_uf),
        .count    (count),
        .zero     (zero),
        .busy     (busy),
        .underflow(underflow),
        .sticky_uf(sticky_uf)
    );

    typedef struct {
        bit       rst;
        bit       load;
        bit [3:0] val;
        bit       dec;
        bit       clr;
        bit [3:0] e_count;
        bit       e_zero;
        bit       e_busy;
        bit       e_uf;
        bit       e_sticky;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit [3:0] v, input bit d, input bit c);
        if (r) begin
            m_count = 0; m_loaded = 0; m_uf = 0; m_sticky = 0;
        end else if (l) begin
            m_count = v; m_loaded = 1; m_uf = 0; m_sticky = m_sticky && !c;
        end else if (d && m_loaded && m_count == 0) begin
            m_uf = 1; m_sticky = 1;
            m_count = SAT ? 0 : 15;
        end else if (d && m_loaded) begin
            m_count = m_count - 1; m_uf = 0; m_sticky = m_sticky && !c;
        end else begin
            m_uf = 0; m_sticky = m_sticky && !c;
        end
    endtask

    // one clock: drive, edge, update model, sample 1 time unit later and compare to model
    task automatic cyc(input bit r, input bit l, input bit [3:0] v, input bit d, input bit c);
        rst = r; load = l; load_val = v; dec_en = d; clr_uf = c;
        @(posedge clk);
        model_step(r, l, v, d, c);
        #1;
        check("model_count", int'(count), m_count);
        check("model_zero", int'(zero), int'(m_count == 0));
        check("model_busy", int'(busy), int'(m_loaded && m_count != 0));
        check("model_underflow", int'(underflow), int'(m_uf));
        check("model_sticky", int'(sticky_uf), int'(m_sticky));
    endtask

    function automatic vec_t mk(bit r, bit l, bit [3:0] v, bit d, bit c,
                                bit [3:0] ec, bit ez, bit eb, bit eu, bit es);
        vec_t t;
        t.rst = r; t.load = l; t.val = v; t.dec = d; t.clr = c;
        t.e_count = ec; t.e_zero = ez; t.e_busy = eb; t.e_uf = eu; t.e_sticky = es;
        return t;
    endfunction

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; dec_en = 1'b0; clr_uf = 1'b0;

        //        rst ld val dec clr   count z b u s
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  5, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  4, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0));
        if (SAT) begin
            vecs.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 1, 1));
            vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
            vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, 0, 0));
        end else begin
            vecs.push_back(mk(0, 0, 0, 1, 0, 15, 0, 1, 1, 1));
            vecs.push_back(mk(0, 0, 0, 0, 0, 15, 0, 1, 0, 1));
            vecs.push_back(mk(0, 0, 0, 0, 1, 15, 0, 1, 0, 0));
        end
        vecs.push_back(mk(0, 1, 14, 0, 0, 14, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0));
        if (SAT) begin
            vecs.push_back(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 1));
            vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 1));
        end else begin
            vecs.push_back(mk(0, 0, 0, 1, 1, 15, 0, 1, 1, 1));
            vecs.push_back(mk(0, 0, 0, 0, 0, 15, 0, 1, 0, 1));
        end
        vecs.push_back(mk(0, 1, 10, 0, 0, 10, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0,  9, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].load, vecs[i].val, vecs[i].dec, vecs[i].clr);
            check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].e_count));
            check($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].e_zero));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_underflow", i), int'(underflow), int'(vecs[i].e_uf));
            check($sformatf("vec%0d_sticky", i), int'(sticky_uf), int'(vecs[i].e_sticky));
        end

        // repeated decrements at zero: wrap then count down, or pulse every cycle when saturating
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        check("rep1_underflow", int'(underflow), 1);
        check("rep1_count", int'(count), SAT ? 0 : 15);
        cyc(0, 0, 0, 1, 0);
        check("rep2_underflow", int'(underflow), SAT ? 1 : 0);
        check("rep2_count", int'(count), SAT ? 0 : 14);
        cyc(0, 0, 0, 1, 0);
        check("rep3_underflow", int'(underflow), SAT ? 1 : 0);
        check("rep3_sticky", int'(sticky_uf), 1);

        // load of 1 then a single decrement expires immediately
        cyc(0, 1, 1, 0, 1);
        cyc(0, 0, 0, 1, 0);
        check("one_expire_zero", int'(zero), 1);
        check("one_expire_busy", int'(busy), 0);
        check("one_expire_underflow", int'(underflow), 0);

        // randomized stimulus compared against the model every cycle
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_counter_dec.md
Name: down_counter_dec

Overview:
Registered 4-bit down-counting decrementor. It is the counterpart to the team's combinational incrementor and reports a borrow/underflow where that block reports a carry/overflow. It is loaded with a start value, then steps down by one on each enabled cycle and flags underflow on the 0 → max transition. It is used as a countdown/timeout element next to the arithmetic blocks.

Parameters:
WIDTH, 4, data width of load value and count
MAXV, 2**WIDTH-1, wrap value after underflow (derived; do not override)

Ports:
clk       input   1      rising-edge clock
rst       input   1      synchronous, active-high reset
load      input   1      load load_val into count this cycle
load_val  input   WIDTH  start value
dec_en    input   1      decrement request
clr_uf    input   1      clear sticky underflow flag
count     output  WIDTH  current registered value
zero      output  1      count == 0 (registered, same cycle as count)
busy      output  1      high in RUN state
underflow output  1      1-cycle pulse on a decrement from 0
sticky_uf output  1      latched underflow, held until clr_uf or rst

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, count=0, zero=1, busy=0, underflow=0, sticky_uf=0. Reset overrides all other inputs, including mid-count.
- All outputs are registered. Effects are visible the cycle after the triggering edge.
- FSM states: IDLE, RUN, EXPIRED.
- IDLE:
  - dec_en is ignored; count holds.
  - load=1 with load_val≠0 → RUN, count=load_val.
  - load=1 with load_val=0 → EXPIRED, count=0.
- RUN:
  - dec_en=1 → count=count-1.
  - If count was 1, next state is EXPIRED (count=0, zero=1).
  - dec_en=0 → hold.
- EXPIRED:
  - count=0, busy=0.
  - dec_en=1 → underflow pulse=1, sticky_uf=1, count=MAXV (4'b1111), state=RUN.
  - dec_en=0 → hold.
- Priority: rst > load > dec_en.
  - load and dec_en in the same cycle: load wins, no decrement, no underflow.
  - load is accepted in any state, including mid-count in RUN.
- underflow is high for exactly one cycle per 0→MAXV step. Back-to-back dec_en at 0 cannot occur, because the step leaves count=MAXV.
- sticky_uf: set by any underflow, cleared by clr_uf. If set and clear occur in the same cycle, set wins (sticky_uf stays 1).
- Arithmetic is modulo 2^WIDTH. No intermediate value exceeds WIDTH bits except the internal borrow bit.
- zero tracks count exactly (zero=1 iff count==0), including after reset and after a load of 0.

Optional Feature:
Macro DEC_SATURATE_EN.
- Defined: a decrement in EXPIRED does not wrap. count stays 0, state stays EXPIRED, underflow still pulses for 1 cycle, and sticky_uf is set. Repeated dec_en at 0 pulses underflow on every such cycle.
- Undefined: wrap to MAXV and return to RUN, as in Behaviour.

Test Plan:
1. rst=1 for 2 cycles, then release → count=0, zero=1, busy=0, underflow=0, sticky_uf=0, state IDLE. A dec_en pulse then leaves count at 0.
2. load=1 with load_val=5, then dec_en held 5 cycles → count 5,4,3,2,1,0. busy=1 until count reaches 0. zero=1 and busy=0 on the cycle count=0. No underflow.
3. From count=0 (EXPIRED), one dec_en → count=15, underflow high for exactly 1 cycle, sticky_uf=1, busy=1. Then clr_uf → sticky_uf=0.
4. count=14 in RUN, load=1 with load_val=3 and dec_en=1 in the same cycle → count=3, no decrement. Next dec_en → count=2.
5. load with load_val=0 → EXPIRED, zero=1. Then dec_en with clr_uf=1 in the same cycle → underflow=1, sticky_uf remains 1.
6. rst asserted mid-count (count=9) → next cycle count=0, IDLE, flags cleared. With DEC_SATURATE_EN defined: repeat scenario 3 → count stays 0, underflow pulses on every dec_en cycle.
